// File: rtl/sc_engine_if.sv
// sc_engine_if -- character-stream bus between the receive side (bu), the
// sc_engine cipher core and the transmit side (L4).
//
// Signals:
//   bu_rx_data_rdy  rx character valid this cycle (single-cycle pulse)
//   bu_rx_data      received ASCII character
//   L4_tx_data_rdy  tx character valid this cycle (registered pulse)
//   L4_tx_data      ASCII character to transmit, holds between pulses
//   busy            an rx character offered this cycle would be dropped
//   state           engine FSM encoding, for LEDs
//
// Modports:
//   master  the side that feeds characters in and consumes tx output
//   slave   the engine itself
interface sc_engine_if;
  logic       bu_rx_data_rdy;
  logic [7:0] bu_rx_data;
  logic       L4_tx_data_rdy;
  logic [7:0] L4_tx_data;
  logic       busy;
  logic [2:0] state;

  modport master (
    output bu_rx_data_rdy,
    output bu_rx_data,
    input  L4_tx_data_rdy,
    input  L4_tx_data,
    input  busy,
    input  state
  );

  modport slave (
    input  bu_rx_data_rdy,
    input  bu_rx_data,
    output L4_tx_data_rdy,
    output L4_tx_data,
    output busy,
    output state
  );
endinterface

// File: rtl/sc_engine.sv
// sc_engine -- character-driven LFSR stream cipher.
//
// Commands arrive as ASCII characters in IDLE:
//   'L' + LFSR_W/4 hex digits  load a new key (CR aborts, key unchanged)
//   'E' + printable chars      encrypt: each char becomes two uppercase hex
//                              digits of (char ^ psr)
//   'D' + hex digit pairs      decrypt: each pair becomes (byte ^ psr), or
//                              '.' when the result is not printable
//   CR leaves ENC/DEC back to IDLE.
//
// Parameters:
//   LFSR_W  LFSR and key width, multiple of 4, >= 8
//   TAPS    LFSR feedback mask
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   sc_engine_if.slave (rx character in, tx character out, busy, state)
//
// Build option:
//   SC_ECHO_EN  when defined, every character accepted in IDLE or KEY is
//               echoed on the tx side one cycle after receipt.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a command letter L / E / D
// KEY    | collecting key hex digits into the shadow register
// ENC    | encrypting; printable char emits hi hex digit next cycle
// ENC_LO | emitting lo hex digit, LFSR steps, rx is dropped (busy)
// DEC    | decrypting; waiting for the high nibble
// DEC_LO | decrypting; waiting for the low nibble
module sc_engine #(
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(32'h8020_0003)
) (
  input  logic       clk,
  input  logic       rst,
  sc_engine_if.slave bus
);

  localparam int NDIG  = LFSR_W / 4;
  localparam int CNT_W = $clog2(NDIG + 1);

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_D   = 8'h44;
  localparam logic [7:0] CH_E   = 8'h45;
  localparam logic [7:0] CH_L   = 8'h4C;
  localparam logic [7:0] CH_DOT = 8'h2E;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEY    = 3'd1,
    ENC    = 3'd2,
    ENC_LO = 3'd3,
    DEC    = 3'd4,
    DEC_LO = 3'd5
  } stateT;

  stateT stateQ, stateD;

  logic [LFSR_W-1:0] keyQ, keyD;
  logic [LFSR_W-1:0] shadowQ, shadowD;
  logic [LFSR_W-1:0] lfsrQ, lfsrD;
  logic [3:0]        heldNibQ, heldNibD;
  logic [CNT_W-1:0]  digitsLeftQ, digitsLeftD;
  logic              stepPendQ, stepPendD;
  logic              txRdyQ, txRdyD;
  logic [7:0]        txDataQ, txDataD;

  logic              rxRdy;
  logic [7:0]        rxData;
  logic              busy;
  logic              rxValid;
  logic              rxCr;
  logic              rxHex;
  logic              rxPrint;
  logic [3:0]        rxNib;
  logic [7:0]        psr;
  logic [7:0]        encByte;
  logic [7:0]        decByte;
  logic              decPrint;
  logic [LFSR_W-1:0] lfsrSeed;
  logic [LFSR_W-1:0] lfsrStep;
  logic [LFSR_W-1:0] shadowShift;

  function automatic logic [7:0] toHex(input logic [3:0] n);
    if (n < 4'd10) return {4'h3, n};
    return 8'h37 + {4'h0, n};
  endfunction

  assign rxRdy  = bus.bu_rx_data_rdy;
  assign rxData = bus.bu_rx_data;

  // The only state that cannot take a character is ENC_LO, where the
  // second hex digit of the previous byte is going out.
  assign busy    = (stateQ == ENC_LO);
  assign rxValid = rxRdy && !busy;

  assign rxCr    = (rxData == CH_CR);
  assign rxPrint = (rxData >= 8'h20) && (rxData <= 8'h7E);
  assign rxHex   = ((rxData >= 8'h30) && (rxData <= 8'h39)) ||
                   ((rxData >= 8'h41) && (rxData <= 8'h46)) ||
                   ((rxData >= 8'h61) && (rxData <= 8'h66));
  // '0'-'9' have bit 6 clear; 'A'-'F' and 'a'-'f' have bit 6 set and low
  // nibble 1..6, so +9 maps them to 10..15.
  assign rxNib   = rxData[3:0] + (rxData[6] ? 4'd9 : 4'd0);

  assign psr      = lfsrQ[7:0];
  assign encByte  = rxData ^ psr;
  assign decByte  = {heldNibQ, rxNib} ^ psr;
  assign decPrint = (decByte >= 8'h20) && (decByte <= 8'h7E);

  // An all-zero LFSR would lock up, so a zero key seeds it with 1.
  assign lfsrSeed    = (keyQ == '0) ? LFSR_W'(1) : keyQ;
  assign lfsrStep    = {lfsrQ[LFSR_W-2:0], ^(lfsrQ & TAPS)};
  assign shadowShift = {shadowQ[LFSR_W-5:0], rxNib};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateQ <= IDLE;
    else     stateQ <= stateD;
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: begin
        if (rxValid) begin
          if (rxData == CH_L)      stateD = KEY;
          else if (rxData == CH_E) stateD = ENC;
          else if (rxData == CH_D) stateD = DEC;
        end
      end
      KEY: begin
        if (rxValid) begin
          if (rxCr) stateD = IDLE;
          else if (rxHex && (digitsLeftQ == CNT_W'(1))) stateD = IDLE;
        end
      end
      ENC: begin
        if (rxValid) begin
          if (rxCr)         stateD = IDLE;
          else if (rxPrint) stateD = ENC_LO;
        end
      end
      ENC_LO: stateD = ENC;
      DEC: begin
        if (rxValid) begin
          if (rxCr)       stateD = IDLE;
          else if (rxHex) stateD = DEC_LO;
        end
      end
      DEC_LO: begin
        if (rxValid) begin
          if (rxCr)       stateD = IDLE;
          else if (rxHex) stateD = DEC;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    keyD        = keyQ;
    shadowD     = shadowQ;
    lfsrD       = lfsrQ;
    heldNibD    = heldNibQ;
    digitsLeftD = digitsLeftQ;
    stepPendD   = 1'b0;
    txRdyD      = 1'b0;
    txDataD     = txDataQ;

    // A decrypted byte leaves in the cycle after its low nibble arrives;
    // the LFSR advances at the end of that output cycle.
    if (stepPendQ) lfsrD = lfsrStep;

    case (stateQ)
      IDLE: begin
        if (rxValid) begin
          if (rxData == CH_L) begin
            shadowD     = '0;
            digitsLeftD = CNT_W'(NDIG);
          end else if ((rxData == CH_E) || (rxData == CH_D)) begin
            lfsrD = lfsrSeed;
          end
`ifdef SC_ECHO_EN
          txRdyD  = 1'b1;
          txDataD = rxData;
`endif
        end
      end
      KEY: begin
        if (rxValid) begin
          if (rxCr) begin
            shadowD = '0;
          end else if (rxHex) begin
            shadowD     = shadowShift;
            digitsLeftD = digitsLeftQ - CNT_W'(1);
            if (digitsLeftQ == CNT_W'(1)) begin
              keyD  = shadowShift;
              lfsrD = (shadowShift == '0) ? LFSR_W'(1) : shadowShift;
            end
          end
`ifdef SC_ECHO_EN
          txRdyD  = 1'b1;
          txDataD = rxData;
`endif
        end
      end
      ENC: begin
        if (rxValid) begin
          if (rxCr) begin
            heldNibD = 4'h0;
          end else if (rxPrint) begin
            txRdyD   = 1'b1;
            txDataD  = toHex(encByte[7:4]);
            heldNibD = encByte[3:0];
          end
        end
      end
      ENC_LO: begin
        txRdyD   = 1'b1;
        txDataD  = toHex(heldNibQ);
        heldNibD = 4'h0;
        lfsrD    = lfsrStep;
      end
      DEC: begin
        if (rxValid) begin
          if (rxCr)       heldNibD = 4'h0;
          else if (rxHex) heldNibD = rxNib;
        end
      end
      DEC_LO: begin
        if (rxValid) begin
          if (rxCr) begin
            heldNibD = 4'h0;
          end else if (rxHex) begin
            txRdyD    = 1'b1;
            txDataD   = decPrint ? decByte : CH_DOT;
            heldNibD  = 4'h0;
            stepPendD = 1'b1;
          end
        end
      end
      default: begin
        heldNibD = 4'h0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyQ        <= '0;
      shadowQ     <= '0;
      lfsrQ       <= LFSR_W'(1);
      heldNibQ    <= 4'h0;
      digitsLeftQ <= '0;
      stepPendQ   <= 1'b0;
      txRdyQ      <= 1'b0;
      txDataQ     <= 8'h00;
    end else begin
      keyQ        <= keyD;
      shadowQ     <= shadowD;
      lfsrQ       <= lfsrD;
      heldNibQ    <= heldNibD;
      digitsLeftQ <= digitsLeftD;
      stepPendQ   <= stepPendD;
      txRdyQ      <= txRdyD;
      txDataQ     <= txDataD;
    end
  end

  assign bus.L4_tx_data_rdy = txRdyQ;
  assign bus.L4_tx_data     = txDataQ;
  assign bus.busy           = busy;
  assign bus.state          = stateQ;

endmodule

// File: tb/tb_sc_engine.sv
// tb_sc_engine -- directed, table-driven bench for sc_engine (default build,
// LFSR_W=32, default TAPS). Each table row resets the engine, feeds an rx
// string with 4-cycle spacing and compares the collected tx string and the
// final state. Hand-written sequences cover back-to-back rx while busy and
// reset during ENC_LO.
module tb_sc_engine;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sc_engine_if bus();

  sc_engine dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    string      name;
    string      rx;
    string      tx;
    logic [2:0] st;
  } vecT;

  vecT vecs[$];

  int checks   = 0;
  int failures = 0;

  byte unsigned txQ[$];

  always @(negedge clk) begin
    if (bus.L4_tx_data_rdy === 1'b1) txQ.push_back(bus.L4_tx_data);
  end

  function automatic string txStr();
    string s;
    s = "";
    foreach (txQ[i]) s = {s, $sformatf("%c", txQ[i])};
    return s;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkStr(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input string rx, input string tx,
                        input logic [2:0] st);
    vecT v;
    v.name = name;
    v.rx   = rx;
    v.tx   = tx;
    v.st   = st;
    vecs.push_back(v);
  endtask

  // Leaves the caller at a falling edge with rx idle and the tx log empty.
  task automatic doReset();
    rst = 1'b1;
    bus.bu_rx_data_rdy = 1'b0;
    bus.bu_rx_data     = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txQ.delete();
  endtask

  // Called at a falling edge; the character is seen on the next rising edge.
  task automatic sendChar(input byte unsigned c, input int gap);
    bus.bu_rx_data_rdy = 1'b1;
    bus.bu_rx_data     = c;
    @(negedge clk);
    bus.bu_rx_data_rdy = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++) sendChar(s[i], 4);
  endtask

  initial begin
    rst = 1'b1;
    bus.bu_rx_data_rdy = 1'b0;
    bus.bu_rx_data     = 8'h00;

    addVec("enc_basic",    "L00000001EAA",     "4042",   3'd2);
    addVec("dec_basic",    "L00000001D404200", "AA.",    3'd4);
    addVec("zero_key",     "L00000000EA",      "40",     3'd2);
    addVec("key_abort",    "L1234\rEA",        "40",     3'd2);
    addVec("idle_ignore",  "Z\reEA\r",         "40",     3'd0);
    addVec("enc_letters",  "EELD",             "444F42", 3'd2);
    addVec("enc_nonprint", "E\tA\177A",        "4042",   3'd2);
    addVec("dec_nonhex",   "Dx4Q0",            "A",      3'd4);
    addVec("key_lower",    "LffffffffEA",      "BE",     3'd2);
    addVec("dec_cr",       "D4\rEA",           "40",     3'd2);
    addVec("dec_bounds",   "D7f7c2612",        "~. .",   3'd4);
    addVec("enc_bounds",   "E ~",              "217D",   3'd2);
    addVec("key_skip",     "L0000000Z2EA",     "43",     3'd2);
    addVec("enc_cr",       "EA\rDL",           "40",     3'd4);

    doReset();
    checkVal("reset state", 32'(bus.state), 32'd0);
    checkVal("reset tx_rdy", 32'(bus.L4_tx_data_rdy), 32'd0);
    checkVal("reset tx_data", 32'(bus.L4_tx_data), 32'h00);
    checkVal("reset busy", 32'(bus.busy), 32'd0);

    foreach (vecs[k]) begin
      doReset();
      sendStr(vecs[k].rx);
      repeat (6) @(negedge clk);
      checkStr({vecs[k].name, " tx"}, txStr(), vecs[k].tx);
      checkVal({vecs[k].name, " state"}, 32'(bus.state), 32'(vecs[k].st));
    end

    // Back-to-back rx: second character lands in ENC_LO and is dropped.
    doReset();
    sendStr("L00000001E");
    bus.bu_rx_data_rdy = 1'b1;
    bus.bu_rx_data     = 8'h41;
    @(negedge clk);
    checkVal("enc_lo state", 32'(bus.state), 32'd3);
    checkVal("enc_lo busy", 32'(bus.busy), 32'd1);
    checkVal("hi digit rdy", 32'(bus.L4_tx_data_rdy), 32'd1);
    checkVal("hi digit data", 32'(bus.L4_tx_data), 32'h34);
    bus.bu_rx_data = 8'h42;
    @(negedge clk);
    bus.bu_rx_data_rdy = 1'b0;
    checkVal("lo digit rdy", 32'(bus.L4_tx_data_rdy), 32'd1);
    checkVal("lo digit data", 32'(bus.L4_tx_data), 32'h30);
    checkVal("back in enc", 32'(bus.state), 32'd2);
    checkVal("busy released", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkVal("pulse ends", 32'(bus.L4_tx_data_rdy), 32'd0);
    checkVal("tx data holds", 32'(bus.L4_tx_data), 32'h30);
    repeat (3) @(negedge clk);
    checkStr("drop two pulses", txStr(), "40");
    sendChar(8'h41, 4);
    repeat (4) @(negedge clk);
    checkStr("drop no lfsr effect", txStr(), "4042");

    // Reset during ENC_LO loses the pending low digit.
    doReset();
    sendStr("L00000001E");
    bus.bu_rx_data_rdy = 1'b1;
    bus.bu_rx_data     = 8'h41;
    @(negedge clk);
    bus.bu_rx_data_rdy = 1'b0;
    checkVal("pre-reset enc_lo", 32'(bus.state), 32'd3);
    #1 rst = 1'b1;
    #1;
    checkVal("mid reset state", 32'(bus.state), 32'd0);
    checkVal("mid reset tx_data", 32'(bus.L4_tx_data), 32'h00);
    checkVal("mid reset busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkStr("reset drops lo digit", txStr(), "4");
    txQ.delete();
    sendStr("L00000001EA");
    repeat (6) @(negedge clk);
    checkStr("after reset enc", txStr(), "40");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
